// File: rtl/piso_tx.sv
// Framed parallel-to-serial transmitter: start bit (0), DATA_W data bits LSB first,
// stop bit (1), each bit held for CLKS_PER_BIT clocks. The serial line idles high.
`timescale 1ns/1ps
module piso_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_1,
    output logic              busy,
    output logic              tx_done
);

    // Counter widths are $clog2 of their range, never narrower than one bit.
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CntW-1:0]   r_cnt;
    logic [IdxW-1:0]   r_idx;
    logic              r_out;
    logic              r_done;

    logic w_bit_end;

    assign w_bit_end = (r_cnt == LastCnt);

    // Handshake and status are decoded purely from the state register.
    assign in_ready = (r_state == StIdle);
    assign busy     = ~in_ready;
    assign out_1    = r_out;
    assign tx_done  = r_done;

    // Frame sequencer: one state step per bit boundary, line value and done pulse registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_out   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_shift <= in_data;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_out   <= 1'b0;
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        // First data bit goes out as the start bit ends.
                        r_cnt   <= '0;
                        r_out   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= StData;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == LastIdx) begin
                            r_out   <= 1'b1;
                            r_state <= StStop;
                        end else begin
                            r_idx   <= r_idx + IdxW'(1);
                            r_out   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        // Line is already high; it stays high through idle.
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_out   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a queue-based frame model checked every cycle, plus literal frame checks.
`timescale 1ns/1ps
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic       rdy0, line0, busy0, done0;
    logic       rdy1, line1, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    piso_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
        .clk      (clk),
        .reset    (rst_n),
        .in_valid (v0),
        .in_data  (d0),
        .in_ready (rdy0),
        .out_1    (line0),
        .busy     (busy0),
        .tx_done  (done0)
    );

    piso_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk      (clk),
        .reset    (rst_n),
        .in_valid (v1),
        .in_data  (d1),
        .in_ready (rdy1),
        .out_1    (line1),
        .busy     (busy1),
        .tx_done  (done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame bit k: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return d[k-1];
    endfunction

    // Model entries are {line, busy, done} for one cycle.
    localparam logic [2:0] Idle = 3'b100;
    localparam logic [2:0] IdleDone = 3'b101;

    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] cur0 = Idle;
    logic [2:0] cur1 = Idle;

    always @(posedge clk) begin
        if (!rst_n) begin
            q0.delete();
            cur0 = Idle;
        end else begin
            if (!cur0[1] && v0) begin
                for (int k = 0; k < 10; k++)
                    for (int j = 0; j < 4; j++) q0.push_back({frame_bit(d0, k), 2'b10});
                q0.push_back(IdleDone);
            end
            cur0 = (q0.size() > 0) ? q0.pop_front() : Idle;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            q1.delete();
            cur1 = Idle;
        end else begin
            if (!cur1[1] && v1) begin
                for (int k = 0; k < 10; k++) q1.push_back({frame_bit(d1, k), 2'b10});
                q1.push_back(IdleDone);
            end
            cur1 = (q1.size() > 0) ? q1.pop_front() : Idle;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m4_line", 32'(line0), 32'(cur0[2]));
            check("m4_busy", 32'(busy0), 32'(cur0[1]));
            check("m4_ready", 32'(rdy0), 32'(!cur0[1]));
            check("m4_done", 32'(done0), 32'(cur0[0]));
            check("m1_line", 32'(line1), 32'(cur1[2]));
            check("m1_busy", 32'(busy1), 32'(cur1[1]));
            check("m1_ready", 32'(rdy1), 32'(!cur1[1]));
            check("m1_done", 32'(done1), 32'(cur1[0]));
        end
    end

    // Sends one word on the 4-clock DUT from an idle negedge and checks the frame literally.
    task automatic send_frame(input logic [7:0] d, input logic [9:0] pat);
        int nb;
        int done_at;
        nb      = 0;
        done_at = 0;
        v0 = 1'b1;
        d0 = d;
        for (int i = 1; i <= 41; i++) begin
            @(negedge clk);
            if (i <= 40) check("frame_bit", 32'(line0), 32'(pat[(i-1)/4]));
            if (busy0) nb++;
            if (done0 && done_at == 0) done_at = i;
            if (i == 1) begin
                v0 = 1'b0;
                d0 = ~d;
            end
        end
        check("busy_len", 32'(nb), 32'd40);
        check("done_cycle", 32'(done_at), 32'd41);
    endtask

    logic rec_line[0:95];
    logic rec_busy[0:95];
    logic rec_done[0:95];

    initial begin
        int nb;
        int done_at;
        rst_n = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        d0 = 8'h00;
        d1 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_line", 32'(line0), 32'd1);
        check("rst_ready", 32'(rdy0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Released from reset with no valid: line stays idle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_hold", {28'd0, line0, rdy0, busy0, done0}, 32'b1100);
        end

        // A5 on the 4-clock DUT: 0 x4, 1,0,1,0,0,1,0,1 x4, 1 x4.
        send_frame(8'hA5, 10'b1101001010);

        // Back-to-back: valid held high, 00 then FF, data changed mid-frame.
        v0 = 1'b1;
        d0 = 8'h00;
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            rec_line[i] = line0;
            rec_busy[i] = busy0;
            rec_done[i] = done0;
            if (i == 1) d0 = 8'hFF;
            if (i == 42) d0 = 8'h12;
            if (i == 50) v0 = 1'b0;
        end
        for (int i = 1; i <= 36; i++) check("b2b_f1_low", 32'(rec_line[i]), 32'd0);
        for (int i = 37; i <= 40; i++) check("b2b_f1_stop", 32'(rec_line[i]), 32'd1);
        check("b2b_gap_line", 32'(rec_line[41]), 32'd1);
        check("b2b_gap_busy", 32'(rec_busy[41]), 32'd0);
        check("b2b_gap_done", 32'(rec_done[41]), 32'd1);
        for (int i = 42; i <= 45; i++) check("b2b_f2_start", 32'(rec_line[i]), 32'd0);
        for (int i = 46; i <= 81; i++) check("b2b_f2_ones", 32'(rec_line[i]), 32'd1);
        check("b2b_f2_busy", 32'(rec_busy[81]), 32'd1);
        check("b2b_f2_done", 32'(rec_done[82]), 32'd1);
        check("b2b_no_third", 32'(rec_busy[90]), 32'd0);

        // Reset for one cycle during data bit 3 of A5 (cycles 17..20 after accept).
        v0 = 1'b1;
        d0 = 8'hA5;
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i == 1) v0 = 1'b0;
            if (i == 18) rst_n = 1'b0;
            if (i == 19) begin
                check("midrst_line", 32'(line0), 32'd1);
                check("midrst_ready", 32'(rdy0), 32'd1);
                check("midrst_busy", 32'(busy0), 32'd0);
                check("midrst_done", 32'(done0), 32'd0);
                rst_n = 1'b1;
            end
        end
        send_frame(8'h5A, 10'b1010110100);

        // Reset and valid on the same edge: reset wins.
        rst_n = 1'b0;
        v0    = 1'b1;
        d0    = 8'hFF;
        @(negedge clk);
        check("rstv_line", 32'(line0), 32'd1);
        check("rstv_ready", 32'(rdy0), 32'd1);
        check("rstv_busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        v0    = 1'b0;
        @(negedge clk);
        check("rstv_line2", 32'(line0), 32'd1);
        check("rstv_busy2", 32'(busy0), 32'd0);

        // One clock per bit: 3C gives 0,0,0,1,1,1,1,0,0,1 then done.
        nb      = 0;
        done_at = 0;
        v1 = 1'b1;
        d1 = 8'h3C;
        begin
            logic [9:0] pat1;
            pat1 = 10'b1001111000;
            for (int i = 1; i <= 11; i++) begin
                @(negedge clk);
                if (i <= 10) check("c1_bit", 32'(line1), 32'(pat1[i-1]));
                if (busy1) nb++;
                if (done1 && done_at == 0) done_at = i;
                if (i == 1) begin
                    v1 = 1'b0;
                    d1 = 8'h00;
                end
            end
        end
        check("c1_busy_len", 32'(nb), 32'd10);
        check("c1_done_cycle", 32'(done_at), 32'd11);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Framed parallel-to-serial transmitter that drives a single-bit serial line.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits the frame: start bit (0), data bits LSB first, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- Sits on the driving end of the serial line; the receiving end samples that line with registered capture logic.

Parameters:
- DATA_W, 8: width of the parallel word; legal range 1..32.
- CLKS_PER_BIT, 4: clocks each serial bit is held; legal range 1..65535.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk edge).
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  word to transmit.
- in_ready  output  1  transmitter can accept a word this cycle.
- out_1  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values (after a clk edge with reset=0): state IDLE, out_1=1, in_ready=1, busy=0, tx_done=0, shift register and counters cleared.
- State machine, all states registered:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after DATA_W bits.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- in_ready = (state==IDLE). busy = !in_ready. Both are decoded from the state register only, with no combinational path from in_valid.
- Accept: a rising edge with in_valid=1 and in_ready=1 latches in_data into the shift register and enters START.
- in_data and in_valid are ignored whenever in_ready=0. A word is never lost or duplicated.
- out_1 is registered:
  - Goes 0 on the first cycle after the accept edge (latency 1).
  - Held 0 for CLKS_PER_BIT cycles.
  - Then each data bit, bit 0 first, is held CLKS_PER_BIT cycles.
  - Then 1 for CLKS_PER_BIT cycles (stop bit).
- Frame length: exactly (DATA_W+2)*CLKS_PER_BIT cycles of START+DATA+STOP.
- Counters:
  - Bit-time counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit index counts 0..DATA_W-1.
  - Widths are $clog2 of the range, minimum 1 bit.
  - CLKS_PER_BIT=1 must work: one cycle per bit, with no skipped or doubled bits.
- tx_done is registered. It is 1 for exactly one cycle: the first cycle in IDLE after STOP. It is 0 at all other times.
- Back-to-back frames:
  - The earliest new accept is on the edge that ends the first IDLE cycle.
  - This gives a minimum of one idle cycle of out_1=1 between stop and the next start bit.
  - The accept may coincide with tx_done=1.
- Reset mid-frame: on the reset edge, the frame is aborted and the state returns to IDLE. out_1=1, tx_done=0, and the latched word is discarded; no partial bits continue.
- Reset has priority over accept when both occur on the same edge.
- in_valid held high continuously: one word is accepted per frame, at each IDLE cycle.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, send 0xA5:
  - out_1 = 0 x4, then 1,0,1,0,0,1,0,1 (x4 each), then 1 x4.
  - busy=1 for exactly 40 cycles.
  - tx_done pulses once, on cycle 41 after accept.
- Release from reset with in_valid=0:
  - out_1=1, in_ready=1, busy=0, tx_done=0 held for 20 cycles.
- in_valid held high with 0x00 then 0xFF presented:
  - Two frames, separated by exactly one idle-high cycle.
  - Second frame shows eight 1-bits (x4 each).
  - Changing in_data mid-frame has no effect on the current frame.
- CLKS_PER_BIT=1, DATA_W=8, send 0x3C:
  - out_1 sequence 0,0,0,1,1,1,1,0,0,1.
  - Frame lasts 10 cycles; tx_done on cycle 11.
- Assert reset=0 for one cycle during data bit 3 of 0xA5:
  - Next cycle out_1=1, in_ready=1, busy=0, no tx_done.
  - A new accept of 0x5A then transmits a clean full frame.
- Same edge asserts reset=0 and presents in_valid=1:
  - No accept; state stays IDLE and out_1 stays 1.
